// File: rtl/fir_bank_pkg.sv
// Shared types, default sizes and output rounding/saturation for the TDM FIR bank.
package fir_bank_pkg;

  localparam int unsigned DEF_DATA_W    = 24;
  localparam int unsigned DEF_COEF_W    = 18;
  localparam int unsigned DEF_COEF_FRAC = 17;
  localparam int unsigned DEF_TAPS      = 32;
  localparam int unsigned DEF_NUM_BANDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_MAC,
    ST_EMIT
  } state_t;

  // Round half-up at the binary point, drop the fraction, clamp to a data_w-bit signed range.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                    input int unsigned      frac,
                                                    input int unsigned      data_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_bank_tdm_mac.sv
// Signed multiply-accumulate unit; the only arithmetic datapath of the filter bank.
module fir_mac #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned ACC_W  = 47
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clear,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  prod_ext_c;

  assign prod_c     = PROD_W'(sample) * PROD_W'(coef);
  assign prod_ext_c = ACC_W'(prod_c);

  // clear restarts the sum with this cycle's product; en low holds the sum
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clear ? prod_ext_c : acc + prod_ext_c;
    end
  end

endmodule

// File: rtl/fir_bank_tdm.sv
// Time-multiplexed FIR filter bank: one shared delay line, NUM_BANDS coefficient sets,
// one MAC per cycle, one rounded/saturated result pulse per band per accepted sample.
module fir_bank_tdm
  import fir_bank_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned COEF_W    = DEF_COEF_W,
  parameter int unsigned COEF_FRAC = DEF_COEF_FRAC,
  parameter int unsigned TAPS      = DEF_TAPS,
  parameter int unsigned NUM_BANDS = DEF_NUM_BANDS
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  enable,
  input  logic                                                  in_valid,
  output logic                                                  in_ready,
  input  logic signed [DATA_W-1:0]                              audio_in,
  input  logic                                                  coef_we,
  input  logic [$clog2(NUM_BANDS*TAPS)-1:0]                     coef_addr,
  input  logic signed [COEF_W-1:0]                              coef_data,
  output logic                                                  out_valid,
  output logic [(NUM_BANDS > 1 ? $clog2(NUM_BANDS) : 1)-1:0]    out_band,
  output logic signed [DATA_W-1:0]                              out_data,
  output logic                                                  busy
);

  localparam int unsigned ADDR_W = $clog2(NUM_BANDS * TAPS);
  localparam int unsigned BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int unsigned TAP_W  = $clog2(TAPS);
  localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
  localparam int unsigned DEPTH  = NUM_BANDS * TAPS;

  state_t                   state_q;
  state_t                   state_d;
  logic [TAP_W-1:0]         tap_cnt;
  logic [BAND_W-1:0]        band_cnt;
  logic signed [DATA_W-1:0] sample_q;
  logic signed [DATA_W-1:0] dline [TAPS];
  logic signed [COEF_W-1:0] coef_mem [DEPTH];
  logic signed [ACC_W-1:0]  acc;
  logic                     valid_q;

  logic                     accept_c;
  logic                     shift_c;
  logic                     mac_en_c;
  logic                     mac_clr_c;
  logic                     emit_c;
  logic                     coef_wr_c;
  logic                     last_tap_c;
  logic                     last_band_c;
  logic [ADDR_W-1:0]        rd_addr_c;

  assign in_ready    = (state_q == ST_IDLE) && enable && !reset;
  assign accept_c    = in_ready && in_valid;
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = valid_q && enable;
  assign last_tap_c  = (tap_cnt == TAP_W'(TAPS - 1));
  assign last_band_c = (band_cnt == BAND_W'(NUM_BANDS - 1));
  assign rd_addr_c   = ADDR_W'(32'(band_cnt) * TAPS + 32'(tap_cnt));
  // coefficients only change while idle and not racing a sample acceptance
  assign coef_wr_c   = enable && coef_we && !busy && !accept_c && (32'(coef_addr) < DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_c   = 1'b0;
    mac_en_c  = 1'b0;
    mac_clr_c = 1'b0;
    emit_c    = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_c = 1'b1;
          state_d = ST_MAC;
        end
        ST_MAC: begin
          mac_en_c  = 1'b1;
          mac_clr_c = (tap_cnt == '0);
          if (last_tap_c) state_d = ST_EMIT;
        end
        ST_EMIT: begin
          emit_c  = 1'b1;
          state_d = last_band_c ? ST_IDLE : ST_MAC;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tap_cnt  <= '0;
      band_cnt <= '0;
    end else begin
      if (shift_c) begin
        tap_cnt <= '0;
      end else if (mac_en_c) begin
        tap_cnt <= last_tap_c ? '0 : tap_cnt + TAP_W'(1);
      end
      if (shift_c) begin
        band_cnt <= '0;
      end else if (emit_c) begin
        band_cnt <= last_band_c ? '0 : band_cnt + BAND_W'(1);
      end
    end
  end

  // newest sample lives in dline[0]
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= '0;
      for (int k = 0; k < int'(TAPS); k++) dline[k] <= '0;
    end else begin
      if (accept_c) sample_q <= audio_in;
      if (shift_c) begin
        dline[0] <= sample_q;
        for (int k = 1; k < int'(TAPS); k++) dline[k] <= dline[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) coef_mem[i] <= '0;
    end else if (coef_wr_c) begin
      coef_mem[coef_addr] <= coef_data;
    end
  end

  fir_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .en     (mac_en_c),
    .clear  (mac_clr_c),
    .sample (dline[tap_cnt]),
    .coef   (coef_mem[rd_addr_c]),
    .acc    (acc)
  );

  // a pulse registered just before a hold stays pending until enable returns
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      out_band <= '0;
      out_data <= '0;
    end else if (enable) begin
      valid_q <= emit_c;
      if (emit_c) begin
        out_band <= band_cnt;
        out_data <= DATA_W'(round_sat(64'(acc), COEF_FRAC, DATA_W));
      end
    end
  end

endmodule

// File: tb/tb_fir_bank_tdm.sv
// Self-checking bench for fir_bank_tdm: randomized samples/coefficients against a
// sum-of-products reference model, with timing, hold, coefficient-write and reset scenarios.
module tb_fir_bank_tdm;

  localparam int DW    = 24;
  localparam int CW    = 18;
  localparam int CF    = 17;
  localparam int TAPS  = 32;
  localparam int NB    = 10;
  localparam int AW    = 9;
  localparam int BW    = 4;
  localparam int DEPTH = NB * TAPS;
  localparam int LIM   = 600;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] audio_in;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 out_valid;
  logic [BW-1:0]        out_band;
  logic signed [DW-1:0] out_data;
  logic                 busy;

  always #5 clk = ~clk;

  fir_bank_tdm #(
    .DATA_W    (DW),
    .COEF_W    (CW),
    .COEF_FRAC (CF),
    .TAPS      (TAPS),
    .NUM_BANDS (NB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .audio_in  (audio_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_band  (out_band),
    .out_data  (out_data),
    .busy      (busy)
  );

  int     checks   = 0;
  int     failures = 0;
  longint hist [TAPS];
  longint cm   [DEPTH];
  int     p_band [$];
  longint p_data [$];
  int     p_edge [$];
  int     ready_edge;
  logic   acc_ok;

  // Reference: y[b] = floor((sum_k x[k]*c[b][k] + 2^(CF-1)) / 2^CF), clamped to DW bits.
  function automatic longint model_band(int b);
    longint s, q, d, lim;
    s = 0;
    for (int k = 0; k < TAPS; k++) s += hist[k] * cm[b*TAPS + k];
    d = longint'(1) << CF;
    s += d / 2;
    if (s >= 0) q = s / d;
    else        q = -((-s + d - 1) / d);
    lim = longint'(1) << (DW - 1);
    if (q > lim - 1) q = lim - 1;
    if (q < -lim)    q = -lim;
    return q;
  endfunction

  function automatic void model_push(longint x);
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
    for (int a = 0; a < DEPTH; a++) cm[a] = 0;
  endfunction

  function automatic longint rand_sample();
    logic signed [DW-1:0] v;
    v = DW'($urandom);
    return longint'(v);
  endfunction

  function automatic longint rand_coef();
    logic signed [CW-1:0] v;
    v = CW'($urandom);
    return longint'(v);
  endfunction

  task automatic write_coef(input int addr, input longint v);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = AW'(addr);
    coef_data = CW'(v);
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Offers one sample, then records every result pulse with its edge number (acceptance = edge 0).
  task automatic run_sample(input longint x, input int hold_at, input int hold_len,
                            input int wr_at, input int wr_addr, input longint wr_data);
    p_band.delete();
    p_data.delete();
    p_edge.delete();
    @(negedge clk);
    acc_ok   = in_ready;
    in_valid = 1'b1;
    audio_in = DW'(x);
    if (wr_at == 0) begin
      coef_we   = 1'b1;
      coef_addr = AW'(wr_addr);
      coef_data = CW'(wr_data);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    coef_we  = 1'b0;
    audio_in = DW'($urandom);
    ready_edge = -1;
    for (int cyc = 1; cyc <= LIM && ready_edge < 0; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid === 1'b1) begin
        p_band.push_back(int'(out_band));
        p_data.push_back(longint'(out_data));
        p_edge.push_back(cyc);
      end
      if (in_ready === 1'b1) ready_edge = cyc;
      coef_we = 1'b0;
      enable  = !(hold_len > 0 && cyc >= hold_at && cyc < hold_at + hold_len);
      if (wr_at > 0 && cyc == wr_at) begin
        coef_we   = 1'b1;
        coef_addr = AW'(wr_addr);
        coef_data = CW'(wr_data);
      end
    end
    enable  = 1'b1;
    coef_we = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_band !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b data=%0d band=%0d busy=%0b expected all 0",
               out_valid, out_data, out_band, busy);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b expected 0", in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_in_ready: got %0b expected 1", in_ready);
    end
  endtask

  task automatic test_impulse();
    longint x;
    for (int k = 0; k < TAPS; k++) begin
      cm[k] = 65536;
      write_coef(k, 65536);
    end
    for (int s = 0; s < TAPS + 2; s++) begin
      x = (s == 0) ? 1000000 : 0;
      model_push(x);
      run_sample(x, 0, 0, -1, 0, 0);
      checks++;
      if (acc_ok !== 1'b1) begin
        failures++;
        $display("FAIL imp_accept s=%0d: in_ready=%0b expected 1", s, acc_ok);
      end
      checks++;
      if (p_band.size() != NB) begin
        failures++;
        $display("FAIL imp_pulse_count s=%0d: got %0d expected %0d", s, p_band.size(), NB);
      end
      for (int i = 0; i < p_band.size() && i < NB; i++) begin
        checks++;
        if (p_band[i] != i || p_edge[i] != 1 + (i+1)*(TAPS+1) || p_data[i] != model_band(i)) begin
          failures++;
          $display("FAIL imp_band s=%0d i=%0d: band=%0d edge=%0d data=%0d expected band=%0d edge=%0d data=%0d",
                   s, i, p_band[i], p_edge[i], p_data[i], i, 1 + (i+1)*(TAPS+1), model_band(i));
        end
      end
      if (p_band.size() > 0) begin
        checks++;
        if (p_data[0] != ((s < TAPS) ? 500000 : 0)) begin
          failures++;
          $display("FAIL imp_band0_value s=%0d: got %0d expected %0d", s, p_data[0], (s < TAPS) ? 500000 : 0);
        end
      end
      checks++;
      if (ready_edge != 1 + NB*(TAPS+1)) begin
        failures++;
        $display("FAIL imp_ready_edge s=%0d: got %0d expected %0d", s, ready_edge, 1 + NB*(TAPS+1));
      end
    end
  endtask

  task automatic test_random();
    longint x;
    for (int a = 0; a < DEPTH; a++) begin
      cm[a] = rand_coef();
      write_coef(a, cm[a]);
    end
    for (int j = 0; j < 4; j++) write_coef(DEPTH + int'($urandom_range(0, (1 << AW) - DEPTH - 1)), rand_coef());
    for (int s = 0; s < 6; s++) begin
      x = rand_sample();
      model_push(x);
      run_sample(x, 0, 0, -1, 0, 0);
      checks++;
      if (p_band.size() != NB) begin
        failures++;
        $display("FAIL rnd_pulse_count s=%0d: got %0d expected %0d", s, p_band.size(), NB);
      end
      for (int i = 0; i < p_band.size() && i < NB; i++) begin
        checks++;
        if (p_band[i] != i || p_edge[i] != 1 + (i+1)*(TAPS+1) || p_data[i] != model_band(i)) begin
          failures++;
          $display("FAIL rnd_band s=%0d i=%0d: band=%0d edge=%0d data=%0d expected band=%0d edge=%0d data=%0d",
                   s, i, p_band[i], p_edge[i], p_data[i], i, 1 + (i+1)*(TAPS+1), model_band(i));
        end
      end
    end
    repeat (4) @(negedge clk);
    checks++;
    if (out_band !== BW'(NB - 1) || longint'(out_data) != model_band(NB - 1) || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rnd_hold_outputs: band=%0d data=%0d valid=%0b expected band=%0d data=%0d valid=0",
               out_band, out_data, out_valid, NB - 1, model_band(NB - 1));
    end
  endtask

  task automatic test_saturation();
    longint x;
    for (int k = 0; k < TAPS; k++) begin
      cm[k] = 131071;
      write_coef(k, 131071);
    end
    for (int s = 0; s < 2*TAPS; s++) begin
      x = (s < TAPS) ? 8388607 : -8388608;
      model_push(x);
      run_sample(x, 0, 0, -1, 0, 0);
      checks++;
      if (p_band.size() != NB) begin
        failures++;
        $display("FAIL sat_pulse_count s=%0d: got %0d expected %0d", s, p_band.size(), NB);
      end
      for (int i = 0; i < p_band.size() && i < NB; i++) begin
        checks++;
        if (p_band[i] != i || p_data[i] != model_band(i)) begin
          failures++;
          $display("FAIL sat_band s=%0d i=%0d: band=%0d data=%0d expected band=%0d data=%0d",
                   s, i, p_band[i], p_data[i], i, model_band(i));
        end
      end
      if ((s == TAPS - 1 || s == 2*TAPS - 1) && p_band.size() > 0) begin
        checks++;
        if (p_data[0] != ((s < TAPS) ? 8388607 : -8388608)) begin
          failures++;
          $display("FAIL sat_limit s=%0d: got %0d expected %0d", s, p_data[0], (s < TAPS) ? 8388607 : -8388608);
        end
      end
    end
  endtask

  task automatic test_hold();
    longint x;
    int     hold_at [2] = '{10, 210};
    for (int h = 0; h < 2; h++) begin
      x = rand_sample();
      model_push(x);
      run_sample(x, hold_at[h], 5, -1, 0, 0);
      checks++;
      if (p_band.size() != NB) begin
        failures++;
        $display("FAIL hold_pulse_count h=%0d: got %0d expected %0d", h, p_band.size(), NB);
      end
      for (int i = 0; i < p_band.size() && i < NB; i++) begin
        int exp_edge;
        exp_edge = 1 + (i+1)*(TAPS+1) + ((1 + (i+1)*(TAPS+1) > hold_at[h]) ? 5 : 0);
        checks++;
        if (p_band[i] != i || p_edge[i] != exp_edge || p_data[i] != model_band(i)) begin
          failures++;
          $display("FAIL hold_band h=%0d i=%0d: band=%0d edge=%0d data=%0d expected band=%0d edge=%0d data=%0d",
                   h, i, p_band[i], p_edge[i], p_data[i], i, exp_edge, model_band(i));
        end
      end
      checks++;
      if (ready_edge != 1 + NB*(TAPS+1) + 5) begin
        failures++;
        $display("FAIL hold_ready_edge h=%0d: got %0d expected %0d", h, ready_edge, 1 + NB*(TAPS+1) + 5);
      end
    end
  endtask

  task automatic test_coef_busy();
    int     addr_a;
    int     addr_b;
    longint new_a;
    longint x;
    addr_a = 5*TAPS + 0;
    addr_b = 7*TAPS + 0;
    new_a  = (cm[addr_a] > 0) ? cm[addr_a] - 70000 : cm[addr_a] + 70000;
    for (int step = 0; step < 3; step++) begin
      x = rand_sample();
      if (x == 0) x = 12345;
      if (step == 2) begin
        write_coef(addr_a, new_a);
        cm[addr_a] = new_a;
      end
      model_push(x);
      if (step == 0)      run_sample(x, 0, 0, 40, addr_a, new_a);
      else if (step == 1) run_sample(x, 0, 0, 0, addr_b, cm[addr_b] + 1000);
      else                run_sample(x, 0, 0, -1, 0, 0);
      checks++;
      if (p_band.size() != NB) begin
        failures++;
        $display("FAIL coef_pulse_count step=%0d: got %0d expected %0d", step, p_band.size(), NB);
      end
      for (int i = 0; i < p_band.size() && i < NB; i++) begin
        checks++;
        if (p_band[i] != i || p_data[i] != model_band(i)) begin
          failures++;
          $display("FAIL coef_band step=%0d i=%0d: band=%0d data=%0d expected band=%0d data=%0d",
                   step, i, p_band[i], p_data[i], i, model_band(i));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    longint x;
    @(negedge clk);
    in_valid = 1'b1;
    audio_in = DW'(777777);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (109) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy_before: got %0b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_band !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs: valid=%0b data=%0d band=%0d busy=%0b ready=%0b expected all 0",
               out_valid, out_data, out_band, busy, in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    n = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL rstmid_no_pulses: got %0d pulses expected 0", n);
    end
    cm[0] = 65536;
    write_coef(0, 65536);
    cm[1] = 65536;
    write_coef(1, 65536);
    cm[3*TAPS] = rand_coef();
    write_coef(3*TAPS, cm[3*TAPS]);
    for (int s = 0; s < 2; s++) begin
      x = (s == 0) ? 1000000 : 0;
      model_push(x);
      run_sample(x, 0, 0, -1, 0, 0);
      checks++;
      if (p_band.size() != NB) begin
        failures++;
        $display("FAIL rstmid_pulse_count s=%0d: got %0d expected %0d", s, p_band.size(), NB);
      end
      for (int i = 0; i < p_band.size() && i < NB; i++) begin
        checks++;
        if (p_band[i] != i || p_edge[i] != 1 + (i+1)*(TAPS+1) || p_data[i] != model_band(i)) begin
          failures++;
          $display("FAIL rstmid_band s=%0d i=%0d: band=%0d edge=%0d data=%0d expected band=%0d edge=%0d data=%0d",
                   s, i, p_band[i], p_edge[i], p_data[i], i, 1 + (i+1)*(TAPS+1), model_band(i));
        end
      end
      if (p_band.size() > 0) begin
        checks++;
        if (p_data[0] != 500000) begin
          failures++;
          $display("FAIL rstmid_band0_value s=%0d: got %0d expected 500000", s, p_data[0]);
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    audio_in  = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_clear();
    test_reset();
    test_impulse();
    test_random();
    test_saturation();
    test_hold();
    test_coef_busy();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fir_bank_tdm.md
FIR_BANK_TDM -- requirements
Module: fir_bank_tdm

Interface
REQ-001 SHALL have parameter DATA_W, default 24, sample width (signed).
REQ-002 SHALL have parameter COEF_W, default 18, coefficient width (signed).
REQ-003 SHALL have parameter COEF_FRAC, default 17, coefficient fractional bits.
REQ-004 SHALL have parameter TAPS, default 32, taps per band (>=2).
REQ-005 SHALL have parameter NUM_BANDS, default 10, band count (>=1).
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port enable  in  1  global run/hold.
REQ-009 SHALL have port in_valid  in  1  sample offered.
REQ-010 SHALL have port in_ready  out  1  sample accepted when in_valid&in_ready&enable.
REQ-011 SHALL have port audio_in  in  DATA_W  signed sample.
REQ-012 SHALL have port coef_we  in  1  coefficient write strobe.
REQ-013 SHALL have port coef_addr  in  clog2(NUM_BANDS*TAPS)  address band*TAPS+tap.
REQ-014 SHALL have port coef_data  in  COEF_W  signed coefficient.
REQ-015 SHALL have port out_valid  out  1  one-cycle result pulse.
REQ-016 SHALL have port out_band  out  clog2(NUM_BANDS)  band index of out_data.
REQ-017 SHALL have port out_data  out  DATA_W  signed band result.
REQ-018 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> SHIFT (1 cycle) -> MAC (TAPS cycles) -> EMIT (1 cycle) -> MAC for next band, or -> IDLE after band NUM_BANDS-1.
REQ-020 in_ready SHALL be high only in IDLE with enable=1; acceptance SHALL occur in IDLE only.
REQ-021 SHIFT SHALL push the accepted sample into tap 0 of a shared TAPS-deep delay line, oldest discarded.
REQ-022 MAC SHALL clear the accumulator on its first cycle and add x[k]*c[band][k] for k=0..TAPS-1, one product per cycle.
REQ-023 Accumulator width SHALL be DATA_W+COEF_W+clog2(TAPS); no intermediate overflow.
REQ-024 EMIT result SHALL be (acc + 2^(COEF_FRAC-1)) arithmetically shifted right COEF_FRAC, saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-025 For acceptance at edge 0, band b out_valid SHALL be high in the cycle after edge 1+(b+1)*(TAPS+1); out_band=b, exactly one pulse per band.
REQ-026 Next acceptance SHALL be possible no earlier than edge 1+NUM_BANDS*(TAPS+1)+1.
REQ-027 enable=0 SHALL freeze FSM, counters, accumulator, delay line and coefficients; out_valid SHALL be 0 while enable=0; outputs otherwise hold.
REQ-028 Coefficient writes SHALL take effect only when busy=0 and in the same cycle no sample is accepted; otherwise SHALL be ignored.
REQ-029 coef_addr >= NUM_BANDS*TAPS SHALL be ignored.
REQ-030 out_data and out_band SHALL hold last emitted values between pulses.

Reset
REQ-031 reset SHALL asynchronously force IDLE, in_ready=0 until released, busy=0, out_valid=0, out_band=0, out_data=0, accumulator=0, delay line all zero.
REQ-032 Coefficient memory SHALL reset to all zero.
REQ-033 Reset mid-MAC SHALL abort with no further out_valid for that sample.

Structure
REQ-034 Package fir_bank_pkg SHALL hold the FSM state enum, default parameter constants and the saturate/round function.
REQ-035 Sub-module fir_mac (signed multiply, accumulate, clear, hold-on-enable) SHALL be the sole arithmetic unit.

Verification
REQ-036 Impulse: band0 coefs all 65536, others 0; sample 1000000 then zeros -> band0 out 500000 for the first TAPS samples, 0 after; other bands 0.
REQ-037 Timing: defaults, accept at edge 0 -> band0 pulse after edge 34, band9 pulse after edge 331, in_ready high again at edge 331.
REQ-038 Saturation: all band0 coefs 131071, repeated 8388607 -> band0 out 8388607 once line full; repeated -8388608 -> -8388608.
REQ-039 Hold: enable=0 for 5 cycles mid-MAC -> all pulses shift by exactly 5 cycles, values unchanged.
REQ-040 Coef write while busy=1 -> ignored, next-sample result unchanged; same write in IDLE -> applied.
REQ-041 Reset asserted mid-MAC of band 3 -> outputs zero immediately, no further pulses, next accepted impulse gives fresh result with zero history.
